// File: rtl/timer_int_mc.sv
// Multi-channel compare-match interrupt block: edge-detected status with W1C clear.
// Define TIMER_INT_OVF_EN to build the per-channel overrun flags; otherwise int_ovf is 0.
module timer_int_mc #(
  parameter int NCH   = 4,
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   cnt,
  input  logic [NCH*CNT_W-1:0] tcmp,
  input  logic [NCH-1:0]     int_en,
  input  logic               tisr_wr_sel,
  input  logic [31:0]        pwdata,
  input  logic [3:0]         pstrb,
  output logic [NCH-1:0]     int_st,
  output logic [NCH-1:0]     int_ovf,
  output logic [NCH-1:0]     tim_int_vec,
  output logic               tim_int
);

  logic [NCH-1:0] match;
  logic [NCH-1:0] match_q;
  logic [NCH-1:0] ev_set;
  logic [NCH-1:0] st_clr;
  logic [NCH-1:0] st_q;
  logic           unused_bits;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign match[g]  = (cnt == tcmp[g*CNT_W +: CNT_W]);
    assign st_clr[g] = tisr_wr_sel & pwdata[g] & pstrb[g/8];
  end

  // A counter stalled on the compare value yields a single event.
  assign ev_set = match & ~match_q;

  // Set has priority over a same-cycle clear so no event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= '0;
      st_q    <= '0;
    end else begin
      match_q <= match;
      st_q    <= ev_set | (st_q & ~st_clr);
    end
  end

`ifdef TIMER_INT_OVF_EN
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] ovf_clr;
  logic [NCH-1:0] ovf_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ovf
    assign ovf_clr[g] = tisr_wr_sel & pwdata[16+g] & pstrb[2+g/8];
  end

  assign ovf_set = ev_set & st_q & ~st_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

  assign int_ovf = ovf_q;
`else
  assign int_ovf = '0;
`endif

  assign unused_bits = ^{pwdata, pstrb};

  assign int_st      = st_q;
  assign tim_int_vec = st_q & int_en;
  assign tim_int     = |tim_int_vec;

endmodule
